// File: rtl/xor_lrc_arbiter.sv
// xor_lrc_arbiter: round-robin arbiter sharing one XOR (LRC) accumulator among N packet sources.
module xor_lrc_arbiter #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    input  logic [N-1:0]    s_valid,
    input  logic [N*W-1:0]  s_data,
    input  logic [N-1:0]    s_last,
    output logic [N-1:0]    s_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_sum,
    output logic [IW-1:0]   out_id,
    input  logic            out_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [W-1:0] acc;
    logic [W-1:0] word;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic take;
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) pick = IW'((int'(ptr) + k) % N);
    end
    // out_id doubles as the granted index while BUSY
    assign word    = s_data[out_id*W +: W];
    assign take    = (state == BUSY) && s_valid[out_id];
    assign s_ready = (state == BUSY) ? gnt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            acc       <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt       <= '0;
                    gnt[pick] <= 1'b1;
                    out_id    <= pick;
                    acc       <= '0;
                    state     <= BUSY;
                end
                BUSY: if (take) begin
                    acc <= acc ^ word;
                    if (s_last[out_id]) begin
                        out_sum   <= acc ^ word;
                        out_valid <= 1'b1;
                        gnt       <= '0;
                        ptr       <= (out_id == IW'(N - 1)) ? '0 : out_id + 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_lrc_arbiter.sv
// tb_xor_lrc_arbiter: scenario tasks plus randomized packets checked against a round-robin/XOR-fold model.
module tb_xor_lrc_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  req = 0;
    logic [3:0]  gnt;
    logic [3:0]  s_valid = 0;
    logic [31:0] s_data = 0;
    logic [3:0]  s_last = 0;
    logic [3:0]  s_ready;
    logic        out_valid;
    logic [7:0]  out_sum;
    logic [1:0]  out_id;
    logic        out_ready = 1;
    int errors = 0;
    int checks = 0;
    int mptr = 0;
    logic [7:0] pkt [8];

    xor_lrc_arbiter #(.W(8), .N(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .out_valid(out_valid), .out_sum(out_sum), .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int grant(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] fold(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ pkt[i];
        return x;
    endfunction

    task automatic drive_lanes(input int id, input bit v, input logic [7:0] d, input bit l, input bit noise);
        for (int j = 0; j < 4; j++) begin
            if (j == id) begin
                s_valid[j] = v;
                s_data[j*8 +: 8] = d;
                s_last[j] = l;
            end else begin
                s_valid[j] = noise ? 1'($urandom) : 1'b0;
                s_data[j*8 +: 8] = noise ? 8'($urandom) : 8'h00;
                s_last[j] = noise ? 1'($urandom) : 1'b0;
            end
        end
    endtask

    // waits for a grant, then streams pkt[0..n-1] on lane id with optional bubbles and lane noise
    task automatic send(input int id, input int n, input int bub, input bit noise,
                        output logic [3:0] gs, output int wn);
        wn = 0;
        while (gnt == 0 && wn < 10) begin
            tick();
            wn++;
        end
        gs = gnt;
        for (int i = 0; i < n; i++) begin
            if (bub > 0 && $urandom_range(0, 99) < bub) begin
                drive_lanes(id, 1'b0, 8'($urandom), 1'($urandom), noise);
                tick();
            end
            drive_lanes(id, 1'b1, pkt[i], i == n - 1, noise);
            tick();
        end
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic drain(output int c);
        c = 0;
        while (out_valid && c < 20) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (s_ready !== 4'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0000", s_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum: got %h want 00", out_sum); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
        rst = 0;
        tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL idle_no_req_gnt: got %b want 0000", gnt); end
    endtask

    task automatic test_single();
        logic [3:0] gs;
        int wn, c;
        req = 4'b0001;
        out_ready = 1;
        pkt[0] = 8'h12; pkt[1] = 8'h34; pkt[2] = 8'h56;
        send(0, 3, 0, 0, gs, wn);
        checks++; if (gs !== 4'b0001 || wn != 1) begin errors++; $display("FAIL single_gnt: got %b after %0d cycles want 0001 after 1", gs, wn); end
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'h70) begin errors++; $display("FAIL single_sum: got v=%b %h want v=1 70", out_valid, out_sum); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", out_id); end
        drain(c);
        checks++; if (c != 1) begin errors++; $display("FAIL single_valid_len: got %0d want 1", c); end
        mptr = 1;
        req = 0;
    endtask

    task automatic test_round_robin();
        logic [3:0] gs;
        int wn, c, e;
        req = 4'b1111;
        out_ready = 1;
        pkt[0] = 8'hA5;
        for (int p = 0; p < 5; p++) begin
            e = grant(req, mptr);
            send(e, 1, 0, 0, gs, wn);
            checks++; if (gs !== 4'(1 << e) || wn != 1) begin errors++; $display("FAIL rr_gnt%0d: got %b after %0d want %b after 1", p, gs, wn, 4'(1 << e)); end
            checks++; if (out_sum !== 8'hA5 || out_id !== 2'(e)) begin errors++; $display("FAIL rr_result%0d: got %h id %0d want a5 id %0d", p, out_sum, out_id, e); end
            drain(c);
            checks++; if (c != 1 || gnt !== 4'b0) begin errors++; $display("FAIL rr_gap%0d: got valid %0d gnt %b want 1 0000", p, c, gnt); end
            mptr = (e + 1) % 4;
        end
        req = 0;
    endtask

    task automatic test_backpressure();
        logic [3:0] gs;
        int wn, c;
        req = 4'b0001;
        out_ready = 0;
        pkt[0] = 8'hFF; pkt[1] = 8'h0F;
        send(0, 2, 100, 0, gs, wn);
        checks++; if (gs !== 4'b0001) begin errors++; $display("FAIL bp_gnt: got %b want 0001", gs); end
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 8'hF0 || gnt !== 4'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h gnt %b want v=1 f0 0000", i, out_valid, out_sum, gnt); end
            tick();
        end
        out_ready = 1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", out_valid); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_next_gnt: got %b want 0010", gnt); end
        mptr = 1;
        pkt[0] = 8'h5A;
        send(1, 1, 0, 0, gs, wn);
        checks++; if (out_sum !== 8'h5A || out_id !== 2'd1) begin errors++; $display("FAIL bp_next_sum: got %h id %0d want 5a id 1", out_sum, out_id); end
        drain(c);
        mptr = 2;
        req = 0;
    endtask

    task automatic test_isolation();
        int c;
        req = 4'b0100;
        out_ready = 1;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL iso_gnt: got %b want 0100", gnt); end
        s_valid = 4'b0101;
        s_last = 4'b0001;
        s_data = {8'h00, 8'h11, 8'h00, 8'hFF};
        #1;
        checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL iso_ready: got %b want 0100", s_ready); end
        tick();
        req = 0;
        checks++; if (out_valid !== 1'b0 || gnt !== 4'b0100) begin errors++; $display("FAIL iso_no_end: got v=%b gnt %b want v=0 0100", out_valid, gnt); end
        s_data[23:16] = 8'h22;
        s_last = 4'b0101;
        tick();
        s_valid = 0;
        s_last = 0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'h33 || out_id !== 2'd2) begin errors++; $display("FAIL iso_sum: got v=%b %h id %0d want v=1 33 id 2", out_valid, out_sum, out_id); end
        drain(c);
        mptr = 3;
    endtask

    task automatic test_reset_mid();
        logic [3:0] gs;
        int wn, c;
        req = 4'b0010;
        out_ready = 1;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt: got %b want 0010", gnt); end
        drive_lanes(1, 1'b1, 8'h81, 1'b0, 0);
        tick();
        drive_lanes(1, 1'b1, 8'h42, 1'b0, 0);
        tick();
        #2;
        rst = 1;
        #1;
        checks++; if (gnt !== 4'b0 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_id !== 2'd0 || s_ready !== 4'b0) begin
            errors++; $display("FAIL rm_async: got gnt %b v=%b %h id %0d rdy %b want all zero", gnt, out_valid, out_sum, out_id, s_ready);
        end
        s_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        req = 4'b1000;
        mptr = 0;
        pkt[0] = 8'h07; pkt[1] = 8'h70;
        send(grant(req, mptr), 2, 0, 1, gs, wn);
        checks++; if (gs !== 4'b1000 || wn != 1) begin errors++; $display("FAIL rm_regrant: got %b after %0d want 1000 after 1", gs, wn); end
        checks++; if (out_sum !== 8'h77 || out_id !== 2'd3) begin errors++; $display("FAIL rm_sum: got %h id %0d want 77 id 3", out_sum, out_id); end
        drain(c);
        mptr = 0;
        req = 0;
    endtask

    task automatic test_identities();
        logic [3:0] gs;
        int wn, c;
        out_ready = 1;
        req = 4'b0001;
        pkt[0] = 8'h3C; pkt[1] = 8'h3C;
        send(0, 2, 0, 1, gs, wn);
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'h00) begin errors++; $display("FAIL id_3c3c: got v=%b %h want v=1 00", out_valid, out_sum); end
        drain(c);
        req = 4'b0010;
        pkt[0] = 8'h81;
        send(1, 1, 0, 0, gs, wn);
        checks++; if (out_sum !== 8'h81) begin errors++; $display("FAIL id_81: got %h want 81", out_sum); end
        drain(c);
        req = 4'b0100;
        pkt[0] = 8'h00;
        send(2, 1, 0, 0, gs, wn);
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_id !== 2'd2) begin errors++; $display("FAIL id_zero: got v=%b %h id %0d want v=1 00 id 2", out_valid, out_sum, out_id); end
        drain(c);
        mptr = 3;
        req = 0;
    endtask

    task automatic test_random();
        logic [3:0] gs;
        logic [7:0] exp_sum;
        int wn, c, e, n;
        for (int p = 0; p < 25; p++) begin
            req = 4'($urandom_range(1, 15));
            e = grant(req, mptr);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
            exp_sum = fold(n);
            out_ready = 1'($urandom_range(0, 1));
            send(e, n, 30, 1, gs, wn);
            checks++; if (gs !== 4'(1 << e)) begin errors++; $display("FAIL rnd_gnt%0d: got %b want %b", p, gs, 4'(1 << e)); end
            checks++; if (out_valid !== 1'b1 || out_sum !== exp_sum || out_id !== 2'(e)) begin
                errors++; $display("FAIL rnd_result%0d: got v=%b %h id %0d want v=1 %h id %0d", p, out_valid, out_sum, out_id, exp_sum, e);
            end
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) tick();
                checks++; if (out_valid !== 1'b1 || out_sum !== exp_sum || gnt !== 4'b0) begin
                    errors++; $display("FAIL rnd_hold%0d: got v=%b %h gnt %b want v=1 %h 0000", p, out_valid, out_sum, gnt, exp_sum);
                end
                out_ready = 1;
            end
            drain(c);
            checks++; if (c != 1) begin errors++; $display("FAIL rnd_drain%0d: got %0d want 1", p, c); end
            mptr = (e + 1) % 4;
        end
        req = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_identities();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
